alu_control_mdu: RTL and testbench
==================================

Name: alu_control_mdu

Overview:
- Parametrised successor to the single-cycle ALU decoder for the multicycle MIPS datapath.
- Decodes ALUOp/funct into ALUControl and also sequences multi-cycle MULT/MULTU/DIV/DIVU operations.
- Produces busy/stall, HI/LO write-enable and MFHI/MFLO select for the main FSM and the HI/LO register pair.
- Sits in the execute stage beside the ALU; arithmetic itself lives in the datapath.

Parameters:
- CTRL_W, 4, ALUControl width; codes below are zero-extended when CTRL_W > 4 (CTRL_W >= 4 required).
- MUL_CYCLES, 4, RUN cycles for MULT/MULTU (>= 1).
- DIV_CYCLES, 32, RUN cycles for DIV/DIVU (>= 1).
- CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- ALUOp  in  2  from main control.
- funct  in  6  instruction bits [5:0].
- start  in  1  execute-state issue strobe from main FSM.
- ALUControl  out  CTRL_W  ALU operation code (combinational).
- hilo_sel  out  1  1 = MFHI, 0 = MFLO (combinational).
- stall  out  1  main FSM must hold the current state (combinational).
- mdu_busy  out  1  MDU sequence in progress (registered).
- mdu_done  out  1  one-cycle completion pulse (registered).
- hilo_we  out  1  HI/LO write enable, equal to mdu_done.
- mdu_op  out  2  captured op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (registered).

Behaviour:
- ALUControl codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, SLL 1000, SRL 1001, SRA 1010, SLTU 1011, NOR 1100.
- ALUOp decode: 00 -> ADD; 01 -> SUB; 11 -> OR; 10 -> funct decode.
- Funct decode:
  - 20/21 ADD; 22/23 SUB; 24 AND; 25 OR; 26 XOR; 27 NOR.
  - 2A SLT; 2B SLTU; 00 SLL; 02 SRL; 03 SRA.
  - MDU functs 18/19/1A/1B, MFHI 10, MFLO 12, and any unlisted funct -> ADD.
- hilo_sel = (funct == 6'h10), independent of ALUOp.
- mdu_req = start & ALUOp==10 & funct in {18,19,1A,1B}.
- hilo_rd = start & ALUOp==10 & funct in {10,12}.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on mdu_req, capture mdu_op = funct[1:0], load cnt = N-1 (N = MUL_CYCLES if funct[1]==0, else DIV_CYCLES), go to RUN.
  - RUN: mdu_busy=1. If cnt==0, go to DONE; else cnt decrements by 1.
  - DONE: mdu_done=1 and hilo_we=1 for exactly one cycle. On mdu_req, accept a new op exactly as IDLE does and go to RUN; otherwise go to IDLE.
- Latency: request sampled at edge k -> mdu_busy high for cycles k+1..k+N -> mdu_done high in cycle k+N+1.
- stall = (state==RUN) & (mdu_req | hilo_rd).
  - While RUN, a new MDU request or MFHI/MFLO is not accepted; it is held by the FSM.
  - Non-MDU instructions never stall.
- mdu_op holds its value until the next accept.
- Reset (asynchronous, any state including mid-RUN):
  - state=IDLE, cnt=0, mdu_busy=0, mdu_done=0, hilo_we=0, mdu_op=00.
  - No hilo_we is issued for an aborted operation.
- start deasserted or ALUOp != 10: FSM is unaffected; ALUControl is still driven combinationally.

Optional Feature:
- Macro: ALU_CONTROL_ILLEGAL_EN.
- Defined:
  - Adds output illegal_funct (1 bit, registered, reset 0).
  - Pulses for one cycle after an edge where start & ALUOp==10 & funct is not in the decode table.
  - ALUControl is still ADD for that funct.
- Undefined: the port and its logic are absent; unlisted functs silently decode to ADD.

Test Plan:
- Reset, then ALUOp=10 with funct sweep 20,22,24,25,26,27,2A,2B,00,02,03 -> ALUControl = 0010,0110,0000,0001,0011,1100,0111,1011,1000,1001,1010. ALUOp=00/01/11 -> 0010/0110/0001.
- start=1, ALUOp=10, funct=18 at edge 0 -> mdu_busy high cycles 1-4, mdu_done=hilo_we=1 in cycle 5 only, mdu_op=00.
- funct=1B, DIV_CYCLES=32 -> mdu_busy for 32 cycles; during RUN, issue funct=10 with start -> stall=1, hilo_sel=1; in DONE cycle stall=0; mdu_op=11.
- In the DONE cycle of a MULT, issue funct=1A -> mdu_done=1 that cycle, next cycle mdu_busy=1 with 32-cycle sequence, mdu_op=10.
- Assert rst asynchronously in cycle 2 of a MULT -> all outputs 0 immediately; no hilo_we afterwards; a following MULTU runs normally with mdu_op=01.
- With ALU_CONTROL_ILLEGAL_EN, start & ALUOp=10 & funct=3F -> illegal_funct=1 for one cycle, ALUControl=0010; funct=20 -> illegal_funct stays 0.

Source files
------------

// File: rtl/alu_control_mdu.sv
// alu_control_mdu: ALUOp/funct decoder plus MULT/DIV sequencer; ALU_CONTROL_ILLEGAL_EN adds illegal_funct
module alu_control_mdu #(
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        ALUOp,
    input  logic [5:0]        funct,
    input  logic              start,
    output logic [CTRL_W-1:0] ALUControl,
    output logic              hilo_sel,
    output logic              stall,
    output logic              mdu_busy,
    output logic              mdu_done,
    output logic              hilo_we,
    output logic [1:0]        mdu_op
`ifdef ALU_CONTROL_ILLEGAL_EN
    ,
    output logic              illegal_funct
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [3:0]       w_code;
    logic [1:0]       r_op;
    logic             r_busy, r_done;
    logic             w_funct_op, w_mdu_req, w_hilo_rd, w_accept;
    always_comb begin
        w_code = 4'b0010;
        case (funct)
            6'h22, 6'h23: w_code = 4'b0110;
            6'h24:        w_code = 4'b0000;
            6'h25:        w_code = 4'b0001;
            6'h26:        w_code = 4'b0011;
            6'h27:        w_code = 4'b1100;
            6'h2A:        w_code = 4'b0111;
            6'h2B:        w_code = 4'b1011;
            6'h00:        w_code = 4'b1000;
            6'h02:        w_code = 4'b1001;
            6'h03:        w_code = 4'b1010;
            default:      w_code = 4'b0010;
        endcase
    end
    assign ALUControl = CTRL_W'(ALUOp == 2'b00 ? 4'b0010 :
                                ALUOp == 2'b01 ? 4'b0110 :
                                ALUOp == 2'b11 ? 4'b0001 : w_code);
    assign hilo_sel   = funct == 6'h10;
    assign w_funct_op = start & (ALUOp == 2'b10);
    assign w_mdu_req  = w_funct_op & (funct[5:2] == 4'b0110);
    assign w_hilo_rd  = w_funct_op & (funct == 6'h10 | funct == 6'h12);
    // Requests arriving while RUN are held by the main FSM and retried later
    assign stall      = (r_state == RUN) & (w_mdu_req | w_hilo_rd);
    assign w_accept   = w_mdu_req & (r_state != RUN);
    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        if (w_accept) begin
            w_next = RUN;
            w_cnt  = funct[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
        end else if (r_state == RUN) begin
            w_next = (r_cnt == '0) ? DONE : RUN;
            w_cnt  = (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
        end else if (r_state == DONE) begin
            w_next = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_op    <= 2'b00;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_busy  <= w_next == RUN;
            r_done  <= w_next == DONE;
            if (w_accept) r_op <= funct[1:0];
        end
    end
    assign mdu_busy = r_busy;
    assign mdu_done = r_done;
    assign hilo_we  = r_done;
    assign mdu_op   = r_op;
`ifdef ALU_CONTROL_ILLEGAL_EN
    logic w_known, r_illegal;
    assign w_known = funct inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                   6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03,
                                   6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_illegal <= 1'b0;
        else     r_illegal <= w_funct_op & ~w_known;
    end
    assign illegal_funct = r_illegal;
`endif
endmodule

// File: tb/tb_alu_control_mdu.sv
// tb_alu_control_mdu: cycle-indexed schedule model plus directed literal checks
module tb_alu_control_mdu;
    localparam int MULN = 4;
    localparam int DIVN = 32;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [1:0] ALUOp = 2'b00;
    logic [5:0] funct = 6'h20;
    logic [3:0] ALUControl;
    logic       hilo_sel, stall, mdu_busy, mdu_done, hilo_we;
    logic [1:0] mdu_op;
`ifdef ALU_CONTROL_ILLEGAL_EN
    logic       illegal_funct;
`endif
    alu_control_mdu dut (
        .clk(clk), .rst(rst), .ALUOp(ALUOp), .funct(funct), .start(start),
        .ALUControl(ALUControl), .hilo_sel(hilo_sel), .stall(stall),
        .mdu_busy(mdu_busy), .mdu_done(mdu_done), .hilo_we(hilo_we), .mdu_op(mdu_op)
`ifdef ALU_CONTROL_ILLEGAL_EN
        , .illegal_funct(illegal_funct)
`endif
    );
    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, n = 0;
    int cyc = 0;
    bit go = 1'b0;
    // Model: an accepted op at the edge ending cycle t owns cycles t+1..t+N busy and t+N+1 done
    int m_bs = 0, m_be = -1, m_done = -1;
    logic [1:0] m_op = 2'b00;
    logic m_ill = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_ctrl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b0001;
        case (f)
            6'h22, 6'h23: return 4'b0110;
            6'h24: return 4'b0000;
            6'h25: return 4'b0001;
            6'h26: return 4'b0011;
            6'h27: return 4'b1100;
            6'h2A: return 4'b0111;
            6'h2B: return 4'b1011;
            6'h00: return 4'b1000;
            6'h02: return 4'b1001;
            6'h03: return 4'b1010;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic bit known(input logic [5:0] f);
        return f inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                         6'h00, 6'h02, 6'h03, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12};
    endfunction

    function automatic bit busy_at(input int c);
        return c >= m_bs && c <= m_be;
    endfunction

    wire is_fn  = start && ALUOp == 2'b10;
    wire is_req = is_fn && (funct inside {6'h18, 6'h19, 6'h1A, 6'h1B});
    wire is_hrd = is_fn && (funct == 6'h10 || funct == 6'h12);

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bs <= 0; m_be <= -1; m_done <= -1; m_op <= 2'b00; m_ill <= 1'b0;
        end else begin
            if (is_req && !busy_at(cyc)) begin
                m_bs   <= cyc + 1;
                m_be   <= cyc + (funct[1] ? DIVN : MULN);
                m_done <= cyc + (funct[1] ? DIVN : MULN) + 1;
                m_op   <= funct[1:0];
            end
            m_ill <= is_fn && !known(funct);
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("m_ctrl", ALUControl, exp_ctrl(ALUOp, funct));
            chk("m_hilo_sel", hilo_sel, funct == 6'h10);
            chk("m_stall", stall, busy_at(cyc) && (is_req || is_hrd));
            chk("m_busy", mdu_busy, busy_at(cyc));
            chk("m_done", mdu_done, cyc == m_done);
            chk("m_hilo_we", hilo_we, cyc == m_done);
            chk("m_op", mdu_op, m_op);
`ifdef ALU_CONTROL_ILLEGAL_EN
            chk("m_illegal", illegal_funct, m_ill);
`endif
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f);
        start = 1'b1; ALUOp = 2'b10; funct = f;
    endtask

    logic [5:0] sw_f [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
    logic [3:0] sw_c [11] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b1100, 4'b0111,
                              4'b1011, 4'b1000, 4'b1001, 4'b1010};
    logic [1:0] ao_v [3] = '{2'b00, 2'b01, 2'b11};
    logic [3:0] ao_c [3] = '{4'b0010, 4'b0110, 4'b0001};

    initial begin
        tick; tick;
        go = 1'b1;
        chk("rst_busy", mdu_busy, 0); chk("rst_done", mdu_done, 0);
        chk("rst_we", hilo_we, 0);    chk("rst_op", mdu_op, 0);
        rst = 1'b0;
        tick;
        for (int i = 0; i < 11; i++) begin
            ALUOp = 2'b10; funct = sw_f[i]; #1;
            chk("sweep_ctrl", ALUControl, sw_c[i]);
            tick;
        end
        for (int i = 0; i < 3; i++) begin
            ALUOp = ao_v[i]; funct = 6'h2A; #1;
            chk("aluop_ctrl", ALUControl, ao_c[i]);
            tick;
        end
        // MULT latency
        issue(6'h18); tick; start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("mult_busy", mdu_busy, 1); chk("mult_nodone", mdu_done, 0);
            tick;
        end
        chk("mult_done", mdu_done, 1); chk("mult_we", hilo_we, 1);
        chk("mult_busy_off", mdu_busy, 0); chk("mult_op", mdu_op, 2'b00);
        tick;
        chk("mult_done_off", mdu_done, 0);
        // DIVU with held MFHI
        tick;
        issue(6'h1B); tick;
        funct = 6'h10; #1;
        chk("divu_stall", stall, 1); chk("divu_hilo_sel", hilo_sel, 1);
        n = 0;
        while (mdu_busy && n < 100) begin n++; tick; end
        chk("divu_len", n, DIVN);
        chk("divu_done", mdu_done, 1); chk("divu_stall_done", stall, 0);
        chk("divu_op", mdu_op, 2'b11);
        start = 1'b0;
        tick; tick;
        // DIV accepted in MULT's DONE cycle
        issue(6'h18); tick; start = 1'b0;
        repeat (4) tick;
        issue(6'h1A); #1;
        chk("b2b_done", mdu_done, 1);
        tick; start = 1'b0;
        chk("b2b_busy", mdu_busy, 1); chk("b2b_op", mdu_op, 2'b10);
        n = 0;
        while (mdu_busy && n < 100) begin n++; tick; end
        chk("b2b_len", n, DIVN);
        chk("b2b_done2", mdu_done, 1);
        tick; tick;
        // Async reset mid-MULT
        issue(6'h18); tick; start = 1'b0;
        tick;
        rst = 1'b1; #1;
        chk("abort_busy", mdu_busy, 0); chk("abort_done", mdu_done, 0);
        chk("abort_we", hilo_we, 0);    chk("abort_op", mdu_op, 0);
        #3 rst = 1'b0;
        repeat (8) begin
            tick;
            chk("abort_no_we", hilo_we, 0);
        end
        issue(6'h19); tick; start = 1'b0;
        n = 0;
        while (mdu_busy && n < 100) begin n++; tick; end
        chk("multu_len", n, MULN);
        chk("multu_done", mdu_done, 1); chk("multu_op", mdu_op, 2'b01);
        tick; tick;
`ifdef ALU_CONTROL_ILLEGAL_EN
        issue(6'h3F); #1;
        chk("ill_ctrl", ALUControl, 4'b0010);
        tick; start = 1'b0;
        chk("ill_pulse", illegal_funct, 1);
        tick;
        chk("ill_clear", illegal_funct, 0);
        issue(6'h20); tick; start = 1'b0;
        chk("ill_legal", illegal_funct, 0);
        tick;
`endif
        go = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
